// File: rtl/cache_controller_block_pkg.sv
// cache_controller_block_pkg: cache geometry, controller states and line word select
package cache_controller_block_pkg;
  localparam int TAG_BITS    = 20;
  localparam int INDEX_BITS  = 6;
  localparam int OFFSET_BITS = 6;
  localparam int WAYS        = 2;
  localparam int LINE_BITS   = 512;
  localparam int SETS        = 1 << INDEX_BITS;
  localparam int WORD_BITS   = 32;

  typedef enum logic [2:0] {IDLE, CHECK, MEM_READ, FILL, MEM_WRITE} state_t;

  function automatic logic [WORD_BITS-1:0] line_word(input logic [LINE_BITS-1:0] line, input logic [3:0] w);
    return line[w*WORD_BITS +: WORD_BITS];
  endfunction
endpackage

// File: rtl/cache_controller_block_tag_store.sv
// cache_tag_store: per-set tags, valid bits and victim-way (LRU) bits with hit lookup
module cache_tag_store
  import cache_controller_block_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] index,
  input  logic [TAG_BITS-1:0]   tag,
  input  logic                  fill,
  input  logic                  clr,
  input  logic                  touch,
  input  logic                  touch_way,
  output logic                  hit,
  output logic                  hit_way,
  output logic                  victim,
  output logic [SETS-1:0]       lru_store
);
  logic [TAG_BITS-1:0] tags [SETS][WAYS];
  logic [WAYS-1:0]     valid [SETS];
  logic [WAYS-1:0]     match;

  for (genvar w = 0; w < WAYS; w++) begin : g_match
    assign match[w] = valid[index][w] && tags[index][w] == tag;
  end

  assign hit     = |match;
  assign hit_way = match[1];
  assign victim  = lru_store[index];

  // valid and victim bookkeeping: fills claim the victim, hits steer the next victim
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) valid[s] <= '0;
      lru_store <= '0;
    end else begin
      if (fill) begin
        valid[index][victim] <= 1'b1;
        lru_store[index]     <= !victim;
      end
      if (clr) valid[index][hit_way] <= 1'b0;
      if (touch) lru_store[index] <= touch_way;
    end
  end

  // tags need no reset since valid gates every lookup
  always_ff @(posedge clk) begin
    if (fill) tags[index][victim] <= tag;
  end
endmodule

// File: rtl/cache_controller_block.sv
// cache_controller_block: 2-way write-through, no-write-allocate cache controller FSM
module cache_controller_block
  import cache_controller_block_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           phy_addr,
  input  logic [31:0]           data_from_cpu,
  input  logic                  read_mem,
  input  logic                  write_mem,
  output logic [31:0]           data_to_cpu,
  output logic                  hit_miss,
  output logic                  ready_stall,
  output logic [INDEX_BITS-1:0] cache_mem_index,
  output logic [LINE_BITS-1:0]  cache_mem_data_in,
  output logic                  cache_mem_write_en,
  input  logic [LINE_BITS-1:0]  cache_mem_data_out,
  output logic [31:0]           main_mem_addr,
  output logic [31:0]           main_mem_data_out,
  output logic                  main_mem_read_req,
  output logic                  main_mem_write_req,
  input  logic [LINE_BITS-1:0]  main_mem_data_in,
  input  logic                  main_mem_ready
);
  state_t         state;
  logic [31:0]    reg_phy_addr;
  logic [31:0]    reg_data;
  logic           reg_write;
  logic           hit;
  logic           hit_way;
  logic           victim;
  logic [SETS-1:0] lru_store;

  // the SRAM follows the live CPU address while idle so a lookup is ready by CHECK
  always_comb cache_mem_index = rst ? '0 : state == IDLE ? phy_addr[OFFSET_BITS +: INDEX_BITS] : reg_phy_addr[OFFSET_BITS +: INDEX_BITS];

  cache_tag_store u_tags (
    .clk       (clk),
    .rst       (rst),
    .index     (reg_phy_addr[OFFSET_BITS +: INDEX_BITS]),
    .tag       (reg_phy_addr[31 -: TAG_BITS]),
    .fill      (state == FILL),
    .clr       (state == CHECK && reg_write && hit),
    .touch     (state == CHECK && hit),
    .touch_way (reg_write ? hit_way : !hit_way),
    .hit       (hit),
    .hit_way   (hit_way),
    .victim    (victim),
    .lru_store (lru_store)
  );

  // request sequencing with all CPU and memory outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      reg_phy_addr       <= '0;
      reg_data           <= '0;
      reg_write          <= 1'b0;
      data_to_cpu        <= '0;
      hit_miss           <= 1'b0;
      ready_stall        <= 1'b0;
      cache_mem_data_in  <= '0;
      cache_mem_write_en <= 1'b0;
      main_mem_addr      <= '0;
      main_mem_data_out  <= '0;
      main_mem_read_req  <= 1'b0;
      main_mem_write_req <= 1'b0;
    end else begin
      case (state)
        IDLE: if (read_mem || write_mem) begin
          reg_phy_addr <= phy_addr;
          reg_data     <= data_from_cpu;
          reg_write    <= !read_mem;
          ready_stall  <= 1'b1;
          state        <= CHECK;
        end
        CHECK: begin
          hit_miss <= hit;
          if (reg_write) begin
            main_mem_write_req <= 1'b1;
            main_mem_addr      <= reg_phy_addr;
            main_mem_data_out  <= reg_data;
            state              <= MEM_WRITE;
          end else if (hit) begin
            data_to_cpu <= line_word(cache_mem_data_out, reg_phy_addr[5:2]);
            ready_stall <= 1'b0;
            state       <= IDLE;
          end else begin
            main_mem_read_req <= 1'b1;
            main_mem_addr     <= {reg_phy_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            state             <= MEM_READ;
          end
        end
        MEM_READ: begin
          main_mem_read_req <= 1'b0;
          if (main_mem_ready) begin
            cache_mem_data_in  <= main_mem_data_in;
            cache_mem_write_en <= 1'b1;
            data_to_cpu        <= line_word(main_mem_data_in, reg_phy_addr[5:2]);
            state              <= FILL;
          end
        end
        FILL: begin
          cache_mem_write_en <= 1'b0;
          ready_stall        <= 1'b0;
          state              <= IDLE;
        end
        MEM_WRITE: begin
          main_mem_write_req <= 1'b0;
          if (main_mem_ready) begin
            ready_stall <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_controller_block.sv
// tb_cache_controller_block: scoreboard bench with main memory and cache SRAM models
module tb_cache_controller_block;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  phy_addr = '0, data_from_cpu = '0;
  logic         read_mem = 1'b0, write_mem = 1'b0;
  logic [31:0]  data_to_cpu;
  logic         hit_miss, ready_stall;
  logic [5:0]   cache_mem_index;
  logic [511:0] cache_mem_data_in, cache_mem_data_out, main_mem_data_in;
  logic         cache_mem_write_en;
  logic [31:0]  main_mem_addr, main_mem_data_out;
  logic         main_mem_read_req, main_mem_write_req, main_mem_ready;
  logic         mem_ready_q = 1'b0, stray = 1'b0;
  int           mem_cnt = 0;

  cache_controller_block dut (
    .clk(clk), .rst(rst), .phy_addr(phy_addr), .data_from_cpu(data_from_cpu),
    .read_mem(read_mem), .write_mem(write_mem), .data_to_cpu(data_to_cpu),
    .hit_miss(hit_miss), .ready_stall(ready_stall), .cache_mem_index(cache_mem_index),
    .cache_mem_data_in(cache_mem_data_in), .cache_mem_write_en(cache_mem_write_en),
    .cache_mem_data_out(cache_mem_data_out), .main_mem_addr(main_mem_addr),
    .main_mem_data_out(main_mem_data_out), .main_mem_read_req(main_mem_read_req),
    .main_mem_write_req(main_mem_write_req), .main_mem_data_in(main_mem_data_in),
    .main_mem_ready(main_mem_ready)
  );

  always #5 clk = ~clk;

  // main memory: line i holds value i, ready pulses three cycles after a request
  assign main_mem_data_in = 512'(main_mem_addr[31:6]);
  assign main_mem_ready   = mem_ready_q | stray;
  always @(posedge clk) begin
    mem_ready_q <= 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt <= mem_cnt - 1;
      if (mem_cnt == 1) mem_ready_q <= 1'b1;
    end else if (main_mem_read_req || main_mem_write_req) mem_cnt <= 3;
  end

  // cache SRAM: way chosen by the controller's victim bit, read by the latched tag
  logic [511:0] sd [64][2];
  logic [19:0]  st [64][2];
  bit           sv [64][2];
  always_comb begin
    cache_mem_data_out = '0;
    for (int w = 0; w < 2; w++)
      if (sv[cache_mem_index][w] && st[cache_mem_index][w] == dut.reg_phy_addr[31:12])
        cache_mem_data_out = sd[cache_mem_index][w];
  end

  int          rd_cnt = 0, wr_cnt = 0, cw_cnt = 0;
  logic [31:0] last_rd_addr, last_wr_addr, last_wr_data;
  logic [5:0]  last_cw_idx;
  logic        last_cw_way;
  always @(negedge clk) begin
    if (main_mem_read_req) begin rd_cnt++; last_rd_addr = main_mem_addr; end
    if (main_mem_write_req) begin wr_cnt++; last_wr_addr = main_mem_addr; last_wr_data = main_mem_data_out; end
    if (cache_mem_write_en) begin
      cw_cnt++;
      last_cw_idx = cache_mem_index;
      last_cw_way = dut.lru_store[cache_mem_index];
      sd[cache_mem_index][last_cw_way] = cache_mem_data_in;
      st[cache_mem_index][last_cw_way] = dut.reg_phy_addr[31:12];
      sv[cache_mem_index][last_cw_way] = 1'b1;
    end
  end

  typedef struct {bit wr; bit hit; bit way; logic [31:0] data; logic [31:0] addr; logic [31:0] wdata;} exp_t;
  exp_t        sb [$];
  logic [19:0] mtag [64][2];
  bit          mval [64][2];
  bit          mlru [64];
  int          vec = 0, errs = 0;

  task automatic model_clear();
    for (int s = 0; s < 64; s++) begin mval[s][0] = 0; mval[s][1] = 0; mlru[s] = 0; end
  endtask

  task automatic do_op(input bit wr, input logic [31:0] addr, input logic [31:0] data, input bit both);
    exp_t e, g;
    int rd0, wr0, cw0, idx;
    bit h, hw;
    idx = int'(addr[11:6]); h = 0; hw = 0;
    for (int w = 0; w < 2; w++) if (mval[idx][w] && mtag[idx][w] == addr[31:12]) begin h = 1; hw = w[0]; end
    e.wr = wr && !both; e.hit = h; e.addr = addr; e.wdata = data;
    e.data = addr[5:2] == 4'd0 ? {6'b0, addr[31:6]} : 32'd0;
    e.way = h ? hw : mlru[idx];
    if (!e.wr) begin
      if (h) mlru[idx] = !hw;
      else begin mtag[idx][mlru[idx]] = addr[31:12]; mval[idx][mlru[idx]] = 1; mlru[idx] = !mlru[idx]; end
    end else if (h) begin mval[idx][hw] = 0; mlru[idx] = hw; end
    sb.push_back(e);
    rd0 = rd_cnt; wr0 = wr_cnt; cw0 = cw_cnt;
    @(negedge clk);
    phy_addr = addr; data_from_cpu = data; read_mem = !wr || both; write_mem = wr || both;
    @(negedge clk);
    read_mem = 0; write_mem = 0; phy_addr = 32'h0000_5000; data_from_cpu = 32'h1234_5678;
    vec++; if (ready_stall !== 1'b1) begin errs++; $display("FAIL busy %h: ready_stall=%b want 1", addr, ready_stall); end
    for (int i = 0; i < 40 && ready_stall === 1'b1; i++) @(negedge clk);
    g = sb.pop_front();
    vec++; if (ready_stall !== 1'b0) begin errs++; $display("FAIL timeout %h: ready_stall stuck at %b want 0", g.addr, ready_stall); end
    vec++; if (hit_miss !== g.hit) begin errs++; $display("FAIL hit_miss %h: got %b want %b", g.addr, hit_miss, g.hit); end
    if (g.wr) begin
      vec++; if (wr_cnt - wr0 != 1) begin errs++; $display("FAIL wr_req_count %h: got %0d want 1", g.addr, wr_cnt - wr0); end
      vec++; if (last_wr_addr !== g.addr) begin errs++; $display("FAIL wr_addr: got %h want %h", last_wr_addr, g.addr); end
      vec++; if (last_wr_data !== g.wdata) begin errs++; $display("FAIL wr_data %h: got %h want %h", g.addr, last_wr_data, g.wdata); end
      vec++; if (cw_cnt != cw0 || rd_cnt != rd0) begin errs++; $display("FAIL write_side_effects %h: cache writes %0d reads %0d want 0 0", g.addr, cw_cnt - cw0, rd_cnt - rd0); end
    end else begin
      vec++; if (data_to_cpu !== g.data) begin errs++; $display("FAIL data_to_cpu %h: got %h want %h", g.addr, data_to_cpu, g.data); end
      vec++; if (wr_cnt != wr0) begin errs++; $display("FAIL rd_no_write %h: got %0d write reqs want 0", g.addr, wr_cnt - wr0); end
      vec++; if (rd_cnt - rd0 != (g.hit ? 0 : 1) || cw_cnt - cw0 != (g.hit ? 0 : 1)) begin
        errs++; $display("FAIL rd_traffic %h: reads %0d fills %0d want %0d", g.addr, rd_cnt - rd0, cw_cnt - cw0, g.hit ? 0 : 1);
      end
      if (!g.hit) begin
        vec++; if (last_rd_addr !== {g.addr[31:6], 6'b0}) begin errs++; $display("FAIL rd_addr: got %h want %h", last_rd_addr, {g.addr[31:6], 6'b0}); end
        vec++; if (last_cw_idx !== g.addr[11:6] || last_cw_way !== g.way) begin
          errs++; $display("FAIL fill_slot %h: got idx %0d way %0d want idx %0d way %0d", g.addr, last_cw_idx, last_cw_way, g.addr[11:6], g.way);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; phy_addr = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    vec++; if (ready_stall !== 1'b0) begin errs++; $display("FAIL rst_ready_stall: got %b want 0", ready_stall); end
    vec++; if (hit_miss !== 1'b0 || data_to_cpu !== 32'd0) begin errs++; $display("FAIL rst_cpu_out: hit %b data %h want 0 0", hit_miss, data_to_cpu); end
    vec++; if (cache_mem_index !== 6'd0) begin errs++; $display("FAIL rst_index: got %h want 0", cache_mem_index); end
    vec++; if (cache_mem_write_en !== 1'b0 || cache_mem_data_in !== '0) begin errs++; $display("FAIL rst_cache_out: we %b want 0", cache_mem_write_en); end
    vec++; if (main_mem_read_req !== 1'b0 || main_mem_write_req !== 1'b0) begin errs++; $display("FAIL rst_mem_req: rd %b wr %b want 0 0", main_mem_read_req, main_mem_write_req); end
    vec++; if (main_mem_addr !== 32'd0 || main_mem_data_out !== 32'd0) begin errs++; $display("FAIL rst_mem_bus: addr %h data %h want 0 0", main_mem_addr, main_mem_data_out); end
    vec++; if (dut.reg_phy_addr !== 32'd0) begin errs++; $display("FAIL rst_reg_phy_addr: got %h want 0", dut.reg_phy_addr); end
    rst = 0; phy_addr = 0;
    model_clear();
  endtask

  task automatic test_index_follow();
    @(negedge clk); phy_addr = 32'h0000_0FC0;
    #1 vec++; if (cache_mem_index !== 6'h3F) begin errs++; $display("FAIL idle_index: got %h want 3f", cache_mem_index); end
  endtask

  task automatic test_ignore_ready();
    @(negedge clk); stray = 1;
    @(negedge clk); stray = 0;
    vec++; if (ready_stall !== 1'b0) begin errs++; $display("FAIL idle_ready_ignored: ready_stall %b want 0", ready_stall); end
  endtask

  task automatic test_reset_abort();
    int rd0, cw0;
    rd0 = rd_cnt; cw0 = cw_cnt;
    @(negedge clk); phy_addr = 32'h0000_7000; read_mem = 1;
    @(negedge clk); read_mem = 0;
    for (int i = 0; i < 10 && rd_cnt == rd0; i++) @(negedge clk);
    vec++; if (rd_cnt != rd0 + 1) begin errs++; $display("FAIL abort_req_seen: got %0d reqs want 1", rd_cnt - rd0); end
    rst = 1;
    @(negedge clk);
    vec++; if (ready_stall !== 1'b0 || main_mem_read_req !== 1'b0) begin errs++; $display("FAIL abort_reset: ready_stall %b rd_req %b want 0 0", ready_stall, main_mem_read_req); end
    rst = 0; model_clear();
    repeat (8) @(negedge clk);
    vec++; if (ready_stall !== 1'b0 || cw_cnt != cw0 || rd_cnt != rd0 + 1) begin
      errs++; $display("FAIL abort_no_retry: ready_stall %b fills %0d reqs %0d want 0 0 1", ready_stall, cw_cnt - cw0, rd_cnt - rd0);
    end
  endtask

  initial begin
    #500000 $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_index_follow();
    do_op(0, 32'h0000_1000, 0, 0);
    do_op(0, 32'h0000_1000, 0, 0);
    do_op(1, 32'h0000_2000, 32'hCAFE_BABE, 0);
    do_op(0, 32'h0004_1000, 0, 0);
    do_op(0, 32'h0008_1000, 0, 0);
    do_op(0, 32'h0000_1000, 0, 0);
    do_op(0, 32'h0000_3040, 0, 0);
    do_op(1, 32'h0000_3040, 32'h0BAD_F00D, 0);
    do_op(0, 32'h0000_3040, 0, 0);
    do_op(0, 32'h0000_3044, 0, 0);
    do_op(1, 32'h0000_3040, 32'h5555_AAAA, 1);
    test_ignore_ready();
    test_reset_abort();
    do_op(0, 32'h0000_1000, 0, 0);
    do_op(0, 32'h0000_1000, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/cache_controller_block.md
CACHE_CONTROLLER_BLOCK -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-002 SHALL have CPU side: phy_addr in 32; data_from_cpu in 32; read_mem in 1; write_mem in 1; data_to_cpu out 32; hit_miss out 1 (1=hit); ready_stall out 1 (1=busy).
REQ-003 SHALL have cache SRAM side: cache_mem_index out 6; cache_mem_data_in out 512; cache_mem_write_en out 1; cache_mem_data_out in 512 (combinational read of the tag-matching way).
REQ-004 SHALL have main memory side: main_mem_addr out 32; main_mem_data_out out 32; main_mem_read_req out 1; main_mem_write_req out 1; main_mem_data_in in 512; main_mem_ready in 1 (one-cycle completion pulse).

Function
REQ-005 SHALL model a 2-way set-associative cache: 64 sets, 64-byte lines; tag=addr[31:12], index=addr[11:6], word=addr[5:2].
REQ-006 SHALL hold internal tag[64][2] (20 bits), valid[64][2], lru_store[64] (victim way), and the latched request address reg_phy_addr; lru_store and reg_phy_addr are hierarchically readable by those names.
REQ-007 SHALL implement states IDLE, CHECK, MEM_READ, FILL, MEM_WRITE.
REQ-008 IDLE: ready_stall=0; on read_mem or write_mem, latch phy_addr into reg_phy_addr and data_from_cpu, then go to CHECK; read_mem wins when both are asserted.
REQ-009 ready_stall SHALL be 1 in every state except IDLE; requests arriving while busy SHALL be ignored.
REQ-010 cache_mem_index SHALL be phy_addr[11:6] in IDLE and reg_phy_addr[11:6] otherwise.
REQ-011 CHECK: hit means valid and tag equal in either way; hit_miss is registered with the result.
REQ-012 Read hit: register data_to_cpu = word[reg_phy_addr[5:2]] of cache_mem_data_out; set lru_store[index] to the other way; return to IDLE.
REQ-013 Read miss: go to MEM_READ; pulse main_mem_read_req for exactly one cycle; main_mem_addr = {reg_phy_addr[31:6],6'b0}, held until main_mem_ready.
REQ-014 On main_mem_ready in MEM_READ: go to FILL.
REQ-015 FILL, one cycle: cache_mem_write_en=1 and cache_mem_data_in=main_mem_data_in; victim way = lru_store[index]; write the tag and set valid for the victim; invert lru_store[index]; data_to_cpu = selected word of main_mem_data_in; return to IDLE.
REQ-016 Write policy SHALL be write-through, no-write-allocate.
REQ-017 On a write hit: clear valid of the hit way and set lru_store[index] to that way; no cache write.
REQ-018 On any write: MEM_WRITE state; main_mem_write_req pulses for one cycle; main_mem_addr = reg_phy_addr; main_mem_data_out = latched data; both held until main_mem_ready, then return to IDLE.
REQ-019 hit_miss and data_to_cpu SHALL hold their values until the next CHECK or FILL.
REQ-020 main_mem_ready outside MEM_READ or MEM_WRITE SHALL be ignored.

Reset
REQ-021 rst SHALL force IDLE and clear all valid bits, all lru_store bits and reg_phy_addr.
REQ-022 rst SHALL drive all outputs to 0 (ready_stall=0), and SHALL abort any in-flight memory transaction without retry.

Structure
REQ-023 Shared package SHALL hold geometry constants (TAG_BITS=20, INDEX_BITS=6, OFFSET_BITS=6, WAYS=2, LINE_BITS=512) and the state enum.
REQ-024 SHALL contain one sub-module, cache_tag_store, holding the tag, valid and LRU arrays with hit and way outputs; the FSM stays in cache_controller.

Verification
REQ-025 After reset with main memory line i = i and 3-cycle memory latency: read 0x00001000 -> ready_stall goes 1 and then 0; one main_mem_read_req pulse; main_mem_addr=0x1000; one cache write, index 0, way 0; data_to_cpu=64; hit_miss=0.
REQ-026 Then read 0x00001000 -> hit_miss=1; data_to_cpu=64; no main_mem request.
REQ-027 Write 0x00002000 with 0xCAFEBABE -> main_mem_write_req pulse; main_mem_addr=0x2000; main_mem_data_out=0xCAFEBABE; no cache write.
REQ-028 Read 0x00041000 -> fills index 0 way 1; then read 0x00081000 -> evicts way 0 (tag 0x00001).
REQ-029 Then read 0x00001000 -> hit_miss=0 and a refill; also: write hit to a cached line -> the following read misses; rst asserted during MEM_READ -> IDLE with ready_stall=0.
